// File: rtl/dl_frame_reader_pkg.sv
// Shared downlink definitions: RAM geometry defaults and the frame reader FSM encoding.
package dl_frame_reader_pkg;

  localparam int unsigned DL_ADDR_W     = 7;
  localparam int unsigned DL_DATA_W     = 10;
  localparam int unsigned DL_BANK_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } dl_state_e;

endpackage

// File: rtl/dl_skid_buf.sv
// Two-entry valid/ready buffer with registered outputs; occupancy exposed for upstream credit.
module dl_skid_buf #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ_c
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         pop;

  // Output slot refills from the skid entry first so word order is preserved.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    pop          = out_valid_q & out_ready;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = in_valid;
        if (in_valid) skid_data_d = in_data;
      end else begin
        out_valid_d = in_valid;
        if (in_valid) out_data_d = in_data;
      end
    end else if (in_valid) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign occ_c     = 2'(out_valid_q) + 2'(skid_valid_q);

endmodule

// File: rtl/dl_frame_reader.sv
// Downlink frame reader: fetches a notified frame from one RAM bank and streams it with sof/eof.
module dl_frame_reader
  import dl_frame_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DL_ADDR_W,
  parameter int unsigned DATA_W     = DL_DATA_W,
  parameter int unsigned BANK_DEPTH = DL_BANK_DEPTH
) (
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic              frame_rdy,
  input  logic              frame_bank,
  input  logic [ADDR_W-1:0] frame_len,
  output logic [ADDR_W-1:0] raddr,
  output logic              rden,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eof,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned BUF_W = DATA_W + 2;

  dl_state_e         state_q, state_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_bank_q, pend_bank_d;
  logic [ADDR_W-1:0] pend_len_q, pend_len_d;
  logic              inflight_q, inflight_d;
  logic              inflight_sof_q, inflight_sof_d;
  logic              inflight_eof_q, inflight_eof_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic [ADDR_W-1:0] len_in;
  logic              last;
  logic              pop;
  logic              credit_ok;
  logic              pend_take;
  logic              rd_issue;
  logic [1:0]        occ_c;
  logic [BUF_W-1:0]  sb_out;

  // A read may issue only if its data is guaranteed a buffer slot when it lands.
  always_comb begin
    accept    = frame_rdy && (frame_len != '0);
    len_in    = (frame_len > ADDR_W'(BANK_DEPTH)) ? ADDR_W'(BANK_DEPTH) : frame_len;
    last      = (idx_q == len_q - ADDR_W'(1));
    pop       = m_valid & m_ready;
    credit_ok = (3'(occ_c) + 3'(inflight_q)) <= (3'd1 + 3'(pop));
  end

  always_comb begin
    state_d        = state_q;
    bank_d         = bank_q;
    len_d          = len_q;
    idx_d          = idx_q;
    pend_valid_d   = pend_valid_q;
    pend_bank_d    = pend_bank_q;
    pend_len_d     = pend_len_q;
    pend_take      = 1'b0;
    rd_issue       = 1'b0;
    overrun_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          state_d   = ST_READ;
          bank_d    = pend_bank_q;
          len_d     = pend_len_q;
          idx_d     = '0;
          pend_take = 1'b1;
        end else if (accept) begin
          state_d = ST_READ;
          bank_d  = frame_bank;
          len_d   = len_in;
          idx_d   = '0;
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          rd_issue = 1'b1;
          idx_d    = idx_q + ADDR_W'(1);
          if (last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && m_eof && !inflight_q) begin
          if (pend_valid_q) begin
            state_d   = ST_READ;
            bank_d    = pend_bank_q;
            len_d     = pend_len_q;
            idx_d     = '0;
            pend_take = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pend_take) pend_valid_d = 1'b0;

    // Anything not started straight from an empty IDLE competes for the single pending slot.
    if (accept && !(state_q == ST_IDLE && !pend_valid_q)) begin
      if (!pend_valid_q || pend_take) begin
        pend_valid_d = 1'b1;
        pend_bank_d  = frame_bank;
        pend_len_d   = len_in;
      end else begin
        overrun_d = 1'b1;
      end
    end

    inflight_d     = rd_issue;
    inflight_sof_d = rd_issue && (idx_q == '0);
    inflight_eof_d = rd_issue && last;
    busy_d         = (state_d != ST_IDLE) || pend_valid_d;
  end

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bank_q         <= 1'b0;
      len_q          <= '0;
      idx_q          <= '0;
      pend_valid_q   <= 1'b0;
      pend_bank_q    <= 1'b0;
      pend_len_q     <= '0;
      inflight_q     <= 1'b0;
      inflight_sof_q <= 1'b0;
      inflight_eof_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bank_q         <= bank_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      pend_valid_q   <= pend_valid_d;
      pend_bank_q    <= pend_bank_d;
      pend_len_q     <= pend_len_d;
      inflight_q     <= inflight_d;
      inflight_sof_q <= inflight_sof_d;
      inflight_eof_q <= inflight_eof_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  dl_skid_buf #(
    .W (BUF_W)
  ) u_skid (
    .clk       (clk_out),
    .rst_n     (rst_n),
    .in_valid  (inflight_q),
    .in_data   ({inflight_sof_q, inflight_eof_q, rdata}),
    .out_valid (m_valid),
    .out_data  (sb_out),
    .out_ready (m_ready),
    .occ_c     (occ_c)
  );

  // Read strobe depends on this cycle's pop, so it cannot be registered without losing throughput.
  assign rden    = rd_issue;
  assign raddr   = {bank_q, idx_q[ADDR_W-2:0]};
  assign m_sof   = sb_out[BUF_W-1];
  assign m_eof   = sb_out[BUF_W-2];
  assign m_data  = sb_out[DATA_W-1:0];
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_dl_frame_reader.sv
// Scoreboard bench for dl_frame_reader: expected words and read addresses are queued at issue time.
module tb_dl_frame_reader;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 10;

  logic              clk_out = 1'b0;
  logic              rst_n;
  logic              frame_rdy;
  logic              frame_bank;
  logic [ADDR_W-1:0] frame_len;
  logic [ADDR_W-1:0] raddr;
  logic              rden;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eof;
  logic              busy;
  logic              overrun;

  logic [DATA_W-1:0] mem [128];
  logic [11:0]       exp_q [$];
  logic [7:0]        addr_q [$];
  int                sof_hist [$];
  int                eof_hist [$];
  int                first_rd_hist [$];
  int                nchecks = 0;
  int                nerr = 0;
  int                cyc = 0;
  int                outstanding = 0;
  int                ovr_cnt = 0;
  int                ready_mode = 0;
  int                t_last = 0;

  always #5 clk_out = ~clk_out;

  always @(posedge clk_out) cyc <= cyc + 1;

  always @(posedge clk_out) if (rden) rdata <= mem[raddr];

  dl_frame_reader dut (
    .clk_out    (clk_out),
    .rst_n      (rst_n),
    .frame_rdy  (frame_rdy),
    .frame_bank (frame_bank),
    .frame_len  (frame_len),
    .raddr      (raddr),
    .rden       (rden),
    .rdata      (rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_eof      (m_eof),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input int got, input int want);
    nchecks++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Watches the stream and the RAM port every cycle, away from the active edge.
  task automatic monitor();
    logic        stall_prev = 1'b0;
    logic [11:0] stall_word = '0;
    logic [11:0] w;
    logic [11:0] e;
    logic [7:0]  a;
    int          pop;
    forever begin
      @(negedge clk_out);
      if (!rst_n) begin
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        stall_prev  = 1'b0;
      end else begin
        w   = {m_sof, m_eof, m_data};
        pop = (m_valid && m_ready) ? 1 : 0;
        if (stall_prev) begin
          chk("stall_valid", int'(m_valid), 1);
          chk("stall_word", int'(w), int'(stall_word));
        end
        if (pop == 1) begin
          chk("word_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word", int'(w), int'(e));
          end
          if (m_sof) sof_hist.push_back(cyc);
          if (m_eof) eof_hist.push_back(cyc);
        end
        if (rden) begin
          chk("read_expected", int'(addr_q.size() != 0), 1);
          if (addr_q.size() != 0) begin
            a = addr_q.pop_front();
            chk("raddr", int'(raddr), int'(a[6:0]));
            if (a[7]) first_rd_hist.push_back(cyc);
          end
          chk("credit", int'((outstanding - pop) <= 1), 1);
        end
        outstanding = outstanding + (rden ? 1 : 0) - pop;
        if (overrun) ovr_cnt++;
        stall_prev = m_valid && !m_ready;
        stall_word = w;
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk_out);
      #1;
      m_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // One-cycle notification; when a run is expected, queue its words and addresses.
  task automatic pulse(input logic b, input int len, input bit expect_run);
    int n;
    @(posedge clk_out);
    #1;
    frame_rdy  = 1'b1;
    frame_bank = b;
    frame_len  = 7'(len);
    t_last     = cyc;
    if (expect_run) begin
      n = (len > 64) ? 64 : len;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({(i == 0), (i == n - 1), (b ? 10'h200 : 10'h100) + 10'(i)});
        addr_q.push_back({(i == 0), b, 6'(i)});
      end
    end
    @(posedge clk_out);
    #1;
    frame_rdy = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
      @(negedge clk_out);
      n++;
    end
    chk("done_in_budget", int'(!busy && exp_q.size() == 0 && addr_q.size() == 0), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_raddr"}, int'(raddr), 0);
    chk({tag, "_rden"}, int'(rden), 0);
    chk({tag, "_m_data"}, int'(m_data), 0);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_sof"}, int'(m_sof), 0);
    chk({tag, "_m_eof"}, int'(m_eof), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int t;
    int ovr0;
    rst_n      = 1'b0;
    frame_rdy  = 1'b0;
    frame_bank = 1'b0;
    frame_len  = '0;
    m_ready    = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mem[i]      = 10'h100 + 10'(i);
      mem[64 + i] = 10'h200 + 10'(i);
    end
    fork
      monitor();
      drive_ready();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", nchecks);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk_out);
    @(negedge clk_out);
    chk_reset_outputs("reset");
    @(posedge clk_out);
    #1;
    rst_n = 1'b1;

    // Bank 0, len 4, unstalled: latency, markers and busy window.
    sof_hist.delete();
    eof_hist.delete();
    first_rd_hist.delete();
    pulse(1'b0, 4, 1'b1);
    t = t_last;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_out);
      chk("busy_window", int'(busy), int'(k <= 6));
    end
    wait_done(100);
    chk("first_rden_cycle", (first_rd_hist.size() > 0) ? first_rd_hist[0] : -1, t + 1);
    chk("sof_cycle", (sof_hist.size() > 0) ? sof_hist[0] : -1, t + 3);
    chk("eof_cycle", (eof_hist.size() > 0) ? eof_hist[0] : -1, t + 6);

    // Bank 1 full bank, then an oversized length clamped to one bank.
    pulse(1'b1, 64, 1'b1);
    wait_done(300);
    pulse(1'b0, 100, 1'b1);
    wait_done(300);

    // Random backpressure.
    ready_mode = 1;
    pulse(1'b0, 20, 1'b1);
    wait_done(1000);
    ready_mode = 0;
    repeat (2) @(posedge clk_out);

    // Pending frame follows the first; a third notification overruns.
    sof_hist.delete();
    eof_hist.delete();
    first_rd_hist.delete();
    ovr0 = ovr_cnt;
    pulse(1'b0, 8, 1'b1);
    repeat (2) @(posedge clk_out);
    pulse(1'b1, 5, 1'b1);
    pulse(1'b0, 3, 1'b0);
    wait_done(300);
    chk("overrun_pulses", ovr_cnt - ovr0, 1);
    chk("b2b_first_rden", (first_rd_hist.size() > 1) ? first_rd_hist[1] : -1,
        (eof_hist.size() > 0) ? eof_hist[0] + 1 : -2);

    // Zero length is ignored; length one carries both markers.
    pulse(1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_out);
      chk("len0_busy", int'(busy), 0);
    end
    pulse(1'b1, 1, 1'b1);
    wait_done(100);

    // Reset in the middle of a frame, then a fresh short frame.
    pulse(1'b0, 30, 1'b1);
    repeat (8) @(posedge clk_out);
    #1;
    rst_n = 1'b0;
    @(posedge clk_out);
    #1;
    rst_n = 1'b1;
    @(negedge clk_out);
    chk_reset_outputs("midreset");
    pulse(1'b0, 2, 1'b1);
    wait_done(100);

    chk("total_overruns", ovr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/dl_frame_reader.md
# dl_frame_reader

Downlink frame reader on the read side of the downlink dual-port RAM (128 × 10, two 64-word banks). It runs in the `clk_out` domain. When a frame-ready notification arrives, it fetches the frame's words through the RAM's synchronous read port and presents them on a valid/ready stream with start/end-of-frame markers to the downstream encoder. It holds one pending frame, tolerates arbitrary backpressure, and flags dropped frames.

## Interface
Parameters:
- `ADDR_W`, default 7: RAM address width.
- `DATA_W`, default 10: word width.
- `BANK_DEPTH`, default 64: words per bank, equal to 2^(ADDR_W-1).

Ports:
- `clk_out`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `frame_rdy`  in  1  single-cycle pulse; a complete frame is in `frame_bank`. Already synchronised to `clk_out`.
- `frame_bank`  in  1  bank holding the frame; sampled with `frame_rdy`.
- `frame_len`  in  ADDR_W  word count; sampled with `frame_rdy`.
- `raddr`  out  ADDR_W  RAM read address.
- `rden`  out  1  RAM read enable.
- `rdata`  in  DATA_W  RAM read data, valid the cycle after `rden`.
- `m_data`  out  DATA_W  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_sof`  out  1  first word of a frame; qualified by `m_valid`.
- `m_eof`  out  1  last word of a frame; qualified by `m_valid`.
- `busy`  out  1  a frame is being read or drained, or one is pending.
- `overrun`  out  1  one-cycle pulse; a notification was dropped.

## Operation
- **Reset values:** `raddr`=0, `rden`=0, `m_data`=0, `m_valid`=0, `m_sof`=0, `m_eof`=0, `busy`=0, `overrun`=0. FSM returns to IDLE; pending slot, output buffer and counters are cleared.
- **Length handling:**
  - `frame_len`=0: the notification is ignored and is not queued.
  - `frame_len`>BANK_DEPTH: clamped to BANK_DEPTH.
- **Addressing:** `raddr` = {bank, idx[ADDR_W-2:0]}, idx = 0..len-1. A frame never crosses into the other bank.
- **FSM states:**
  - IDLE: on a valid notification (or a pending one), load bank/len, clear idx, go to READ.
  - READ: issue reads while credit permits. After the idx = len-1 read is issued, go to DRAIN.
  - DRAIN: wait until the output buffer and in-flight read are empty and the eof word is accepted. Then go to READ if a frame is pending, else IDLE.
- **Credit rule:**
  - The output buffer is 2 entries.
  - `rden` may be asserted only if (buffer occupancy + in-flight reads − pop this cycle) ≤ 1.
  - Under this rule the buffer never overflows.
  - With `m_ready` held high, throughput is 1 word/cycle.
- **Data capture:** `rdata` is captured into the buffer only in the cycle after `rden`=1. `rden` is otherwise 0, and RAM output is don't-care.
- **Markers:** `m_sof` is tagged on the idx=0 word; `m_eof` on the idx=len-1 word. For len=1, both are set on the same word.
- **Pending slot:** one entry.
  - A `frame_rdy` arriving while not in IDLE goes into the slot if it is empty.
  - If the slot is full, the new notification is dropped, `overrun` pulses, and the slot keeps the older frame.
  - A `frame_rdy` on the same cycle the FSM leaves DRAIN is treated as arriving while busy.
- **Stream rules:** `m_data`/`m_sof`/`m_eof` hold stable while `m_valid`=1 and `m_ready`=0. `m_valid` does not depend combinationally on `m_ready`.

## Timing
- **First-word latency:** `frame_rdy` in cycle t (IDLE) gives `rden`=1 with `raddr`=bank·64 in t+1, `rdata` in t+2, and `m_valid`/`m_sof` in t+3.
- **Unstalled frame:** a len-N frame with `m_ready`=1 occupies t+3 … t+N+2 on the stream. `busy` is high t+1 … t+N+2.
- **Back-to-back frames:** a pending frame's first `rden` occurs the cycle after the previous eof handshake.
- **Reset mid-frame:** takes effect at the next edge and leaves no partial frame resumed.

## Structure
- **Shared downlink package:** `DL_ADDR_W`, `DL_DATA_W`, `DL_BANK_DEPTH`, and a 3-state FSM enum (IDLE/READ/DRAIN).
- **Sub-module:** `dl_skid_buf`, a 2-entry valid/ready buffer carrying {sof, eof, data}, exposing occupancy for the credit check.

## Test plan
- Bank 0 preloaded 0x100+i, `frame_rdy` with len 4, `m_ready`=1 → words 0x100..0x103 in t+3..t+6; sof on 0x100, eof on 0x103; `raddr` 0..3.
- Bank 1, len 64 → `raddr` 64..127, 64 words, eof on the 64th; no access to addresses 0..63.
- Bank 0, len 20, random `m_ready` (50%) → all 20 words delivered in order, none duplicated; credit rule never violated; data stable while stalled.
- Second `frame_rdy` mid-frame, then a third before the second starts → second frame follows the first's eof with no idle cycle; third drops with one `overrun` pulse.
- `frame_rdy` with len 0 → no `rden`, `busy` stays 0; len 1 → a single word with sof=eof=1.
- `rst_n` low mid-frame → all outputs at reset values next cycle; a following len-2 frame streams correctly from idx 0.
